// File: rtl/tdc_multistep_ctrl.sv
// Multistep TDC controller: a coarse cycle counter plus fine delay-line residuals
// give the start/stop interval in fine LSBs, delivered over a valid/ready port.
//
// state   | meaning
// S_IDLE  | waiting for arm, edges ignored
// S_ARMED | waiting for start edge
// S_RUN   | coarse counter running, waiting for stop edge or saturation
// S_CALC  | combine coarse/fine captures into the result register
// S_DONE  | result_valid held until accepted
module tdc_multistep_ctrl #(
    parameter int COARSE_W    = 8,
    parameter int FINE_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     auto_rearm,
    input  logic                     start,
    input  logic                     stop,
    input  logic [(2**FINE_W)-1:0]   fine_start,
    input  logic [(2**FINE_W)-1:0]   fine_stop,
    output logic                     busy,
    output logic [COARSE_W+FINE_W:0] result,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     overflow
);
    localparam int FINE_TAPS = 2**FINE_W;
    localparam int RES_W     = COARSE_W + FINE_W + 1;
    localparam logic [COARSE_W-1:0] CNT_ONE  = {{(COARSE_W-1){1'b0}}, 1'b1};
    // saturation is declared when the next increment would reach all ones
    localparam logic [COARSE_W-1:0] CNT_LAST = {{(COARSE_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_CALC, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] start_sync, stop_sync;
    logic                   start_hist, stop_hist;
    logic                   start_edge, stop_edge;
    logic [COARSE_W-1:0]    cnt, coarse, coarse_nxt;
    logic [FINE_W:0]        pc_start_q, pc_stop_q;
    logic                   cap_start, cap_stop, clr_cnt, ld_coarse, ovf_hit, ovf_pend, accept;
    logic [RES_W:0]         diff;
    logic [RES_W-1:0]       res_clamped;

    function automatic logic [FINE_W:0] popcnt(input logic [FINE_TAPS-1:0] x);
        logic [FINE_W:0] n;
        n = '0;
        for (int i = 0; i < FINE_TAPS; i++)
            n = n + {{FINE_W{1'b0}}, x[i]};
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync <= '0;
            stop_sync  <= '0;
            start_hist <= 1'b0;
            stop_hist  <= 1'b0;
        end else begin
            start_sync <= {start_sync[SYNC_STAGES-2:0], start};
            stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stop};
            start_hist <= start_sync[SYNC_STAGES-1];
            stop_hist  <= stop_sync[SYNC_STAGES-1];
        end
    end

    assign start_edge = start_sync[SYNC_STAGES-1] & ~start_hist;
    assign stop_edge  = stop_sync[SYNC_STAGES-1] & ~stop_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cap_start  = 1'b0;
        cap_stop   = 1'b0;
        clr_cnt    = 1'b0;
        ld_coarse  = 1'b0;
        coarse_nxt = '0;
        ovf_hit    = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: if (arm) state_nxt = S_ARMED;
            S_ARMED: begin
                if (start_edge) begin
                    cap_start = 1'b1;
                    if (stop_edge) begin
                        cap_stop  = 1'b1;
                        ld_coarse = 1'b1;
                        state_nxt = S_CALC;
                    end else begin
                        clr_cnt   = 1'b1;
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (stop_edge) begin
                    cap_stop   = 1'b1;
                    ld_coarse  = 1'b1;
                    coarse_nxt = cnt + CNT_ONE;
                    state_nxt  = S_CALC;
                end else if (cnt == CNT_LAST) begin
                    ovf_hit   = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: state_nxt = S_DONE;
            S_DONE: begin
                if (result_ready) begin
                    accept    = 1'b1;
                    state_nxt = auto_rearm ? S_ARMED : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // one spare top bit catches a negative fine correction for clamping
    assign diff = {2'b00, coarse, {FINE_W{1'b0}}}
                + {{(RES_W-FINE_W){1'b0}}, pc_start_q}
                - {{(RES_W-FINE_W){1'b0}}, pc_stop_q};
    assign res_clamped = diff[RES_W] ? '0 : diff[RES_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            coarse       <= '0;
            pc_start_q   <= '0;
            pc_stop_q    <= '0;
            ovf_pend     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (clr_cnt)
                cnt <= '0;
            else if (state == S_RUN)
                cnt <= cnt + CNT_ONE;
            if (cap_start) pc_start_q <= popcnt(fine_start);
            if (cap_stop)  pc_stop_q  <= popcnt(fine_stop);
            if (ld_coarse) coarse     <= coarse_nxt;
            ovf_pend <= ovf_hit;
            if (state == S_CALC) begin
                result_valid <= 1'b1;
                overflow     <= ovf_pend;
                result       <= ovf_pend ? '1 : res_clamped;
            end else if (accept) begin
                result_valid <= 1'b0;
                overflow     <= 1'b0;
            end
        end
    end

    assign busy = (state == S_ARMED) || (state == S_RUN);

endmodule

// File: tb/tb_tdc_multistep_ctrl.sv
// Self-checking bench for tdc_multistep_ctrl: directed and randomized intervals
// compared against an arithmetic model of the interval/clamp/overflow rules.
module tb_tdc_multistep_ctrl;
    localparam int CW = 8, FW = 4, SS = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        arm = 1'b0, auto_rearm = 1'b0, start = 1'b0, stop = 1'b0;
    logic        result_ready = 1'b0;
    logic [15:0] fine_start = '0, fine_stop = '0;
    logic        busy, result_valid, overflow;
    logic [12:0] result;
    int          total = 0, bad = 0;

    tdc_multistep_ctrl #(.COARSE_W(CW), .FINE_W(FW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .auto_rearm(auto_rearm),
        .start(start), .stop(stop), .fine_start(fine_start), .fine_stop(fine_stop),
        .busy(busy), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] therm(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    // interval of k coarse cycles in fine LSBs; beyond 255 cycles the counter saturates
    function automatic int model(input int k, input int ps, input int pp);
        int v;
        if (k > 255) return 'h1FFF;
        v = k * 16 + ps - pp;
        return (v < 0) ? 0 : v;
    endfunction

    task automatic measure(input string tag, input int k, input int ps, input int pp,
                           input int hold, input bit do_arm, input bit rearm, input bit inject);
        int exp;
        exp = model(k, ps, pp);
        if (do_arm) begin arm = 1'b1; tick(1); arm = 1'b0; end
        check({tag, "_armed_busy"}, busy, 1);
        fine_start = therm(ps);
        fine_stop  = therm(pp);
        start = 1'b1;
        if (k > 0) tick(k);
        stop = 1'b1;
        tick(SS + 1);
        check({tag, "_valid_early"}, result_valid, 0);
        tick(1);
        check({tag, "_valid"}, result_valid, 1);
        check({tag, "_result"}, result, exp);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_busy_done"}, busy, 0);
        for (int i = 0; i < hold; i++) begin
            if (inject) begin
                if (i == 0 || i == 4) begin start = 1'b0; stop = 1'b0; end
                else if (i == 2)      begin start = 1'b1; stop = 1'b1; end
            end
            tick(1);
            check({tag, "_hold_result"}, result, exp);
            check({tag, "_hold_valid"}, result_valid, 1);
        end
        auto_rearm = rearm;
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        auto_rearm = ~rearm;
        check({tag, "_acc_valid"}, result_valid, 0);
        check({tag, "_acc_busy"}, busy, rearm);
        start = 1'b0;
        stop  = 1'b0;
        tick(SS + 2);
    endtask

    initial begin
        int n, ps, pp, k;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick(2);

        measure("basic37", 37, 5, 3, 0, 1'b1, 1'b0, 1'b0);
        measure("same_pos", 0, 9, 2, 1, 1'b1, 1'b0, 1'b0);
        measure("same_clamp", 0, 2, 6, 0, 1'b1, 1'b0, 1'b0);

        // no stop: counter saturates
        arm = 1'b1; tick(1); arm = 1'b0;
        fine_start = therm(7);
        start = 1'b1;
        n = 0;
        while (result_valid !== 1'b1 && n < 400) begin tick(1); n++; end
        check("ovf_latency", n, SS + 2 + 255);
        check("ovf_result", result, model(256, 7, 0));
        check("ovf_flag", overflow, 1);
        auto_rearm = 1'b0;
        result_ready = 1'b1; tick(1); result_ready = 1'b0;
        check("ovf_clear", overflow, 0);
        check("ovf_acc_valid", result_valid, 0);
        check("ovf_acc_busy", busy, 0);
        start = 1'b0; tick(SS + 2);

        // backpressure with injected pulses, then auto-rearm
        ps = $urandom_range(0, 16); pp = $urandom_range(0, 16);
        measure("hold", $urandom_range(5, 40), ps, pp, 10, 1'b1, 1'b1, 1'b1);
        ps = $urandom_range(0, 16); pp = $urandom_range(0, 16);
        measure("rearm12", 12, ps, pp, 0, 1'b0, 1'b0, 1'b0);

        // stop while armed is ignored
        arm = 1'b1; tick(1); arm = 1'b0;
        fine_start = '0; fine_stop = '0;
        stop = 1'b1; tick(1); stop = 1'b0; tick(2);
        start = 1'b1; tick(20);
        stop = 1'b1; tick(SS + 1);
        check("sa_valid_early", result_valid, 0);
        tick(1);
        check("sa_valid", result_valid, 1);
        check("sa_result", result, model(20, 0, 0));
        auto_rearm = 1'b0;
        result_ready = 1'b1; tick(1); result_ready = 1'b0;
        start = 1'b0; stop = 1'b0; tick(SS + 2);

        // reset mid-run
        arm = 1'b1; tick(1); arm = 1'b0;
        start = 1'b1;
        tick(SS + 1 + 50);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", result_valid, 0);
        check("arst_result", result, 0);
        check("arst_ovf", overflow, 0);
        start = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        stop = 1'b1;
        tick(8);
        check("unarmed_valid", result_valid, 0);
        check("unarmed_busy", busy, 0);
        stop = 1'b0; tick(3);

        for (int i = 0; i < 8; i++) begin
            k  = $urandom_range(0, 80);
            ps = $urandom_range(0, 16);
            pp = $urandom_range(0, 16);
            measure("rand", k, ps, pp, $urandom_range(0, 3), 1'b1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
